// File: rtl/ysyx_23060025_axi_rd_slave.sv
// AXI4 read responder (AR/R) over a word-addressed memory with a backdoor write port; optional YSYX_23060025_AXI_RD_RAND_DELAY_EN adds random inter-beat gaps.
// Latency: first beat READ_LAT cycles after the AR handshake, then one beat per cycle while rready holds.
// Backpressure: a stalled beat holds rdata/rresp/rlast; arready stays low until the last beat is accepted.
module ysyx_23060025_axi_rd_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH_W = 10,
    parameter int READ_LAT    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] in_araddr,
    input  logic                  in_arvalid,
    output logic                  in_arready,
    input  logic [7:0]            in_arlen,
    input  logic [2:0]            in_arsize,
    input  logic [1:0]            in_arburst,
    output logic                  in_rvalid,
    input  logic                  in_rready,
    output logic [DATA_WIDTH-1:0] in_rdata,
    output logic [1:0]            in_rresp,
    output logic                  in_rlast,
    input  logic                  mem_wen,
    input  logic [MEM_DEPTH_W-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0] mem_wdata
);

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] LAT_INIT    = 4'(READ_LAT - 1);

`ifdef YSYX_23060025_AXI_RD_RAND_DELAY_EN
    typedef enum logic [1:0] {IDLE, WAIT, BEAT, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT, BEAT} state_t;
`endif

    state_t                  state;
    logic                    arready_q;
    logic                    rvalid_q;
    logic                    rlast_q;
    logic [1:0]              rresp_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [7:0]              len;
    logic [7:0]              beat_cnt;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    err;
    logic [3:0]              lat_cnt;

    logic [DATA_WIDTH-1:0]   mem [0:(1<<MEM_DEPTH_W)-1];

    logic                    req_err;
    logic                    ar_hs;
    logic                    r_hs;
    logic [ADDR_WIDTH-1:0]   nxt_addr;
    logic [ADDR_WIDTH-1:0]   ld_addr;
    logic                    ld_err;
    logic [7:0]              ld_cnt;
    logic [7:0]              ld_len;
    logic [DATA_WIDTH-1:0]   ld_data;
    logic [1:0]              ld_resp;
    logic                    ld_last;
    state_t                  ld_state;

    assign in_arready = arready_q;
    assign in_rvalid  = rvalid_q;
    assign in_rlast   = rlast_q;
    assign in_rresp   = rresp_q;
    assign in_rdata   = rdata_q;

    assign req_err  = in_arburst[1] | (in_arsize > 3'd2);
    assign ar_hs    = in_arvalid & arready_q;
    assign r_hs     = rvalid_q & in_rready;
    assign nxt_addr = (burst == BURST_INCR) ? addr + (ADDR_WIDTH'(1) << size) : addr;

    always_ff @(posedge clock) begin
        if (mem_wen) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

`ifdef YSYX_23060025_AXI_RD_RAND_DELAY_EN
    logic [7:0] lfsr;
    logic [1:0] gap_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign ld_state = (lfsr[1:0] != 2'd0) ? GAP : BEAT;
`else
    assign ld_state = BEAT;
`endif

    // Source of the beat about to be loaded: the request itself, the latched
    // burst, or the advanced address when the current beat is being accepted.
    always_comb begin
        ld_addr = addr;
        ld_err  = err;
        ld_cnt  = beat_cnt;
        ld_len  = len;
        case (state)
            IDLE: begin
                ld_addr = in_araddr;
                ld_err  = req_err;
                ld_cnt  = 8'd0;
                ld_len  = in_arlen;
            end
            BEAT: begin
                ld_addr = nxt_addr;
                ld_cnt  = beat_cnt + 8'd1;
            end
            default: ;
        endcase
        ld_data = ld_err ? '0 : mem[ld_addr[MEM_DEPTH_W+1:2]];
        ld_resp = ld_err ? RESP_SLVERR : RESP_OKAY;
        ld_last = (ld_cnt == ld_len);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            addr      <= '0;
            len       <= '0;
            size      <= '0;
            burst     <= '0;
            err       <= 1'b0;
            beat_cnt  <= '0;
            lat_cnt   <= '0;
`ifdef YSYX_23060025_AXI_RD_RAND_DELAY_EN
            gap_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        addr      <= ld_addr;
                        len       <= in_arlen;
                        size      <= in_arsize;
                        burst     <= in_arburst;
                        err       <= req_err;
                        beat_cnt  <= ld_cnt;
                        lat_cnt   <= LAT_INIT;
                        arready_q <= 1'b0;
                        if (READ_LAT == 1) begin
                            rdata_q  <= ld_data;
                            rresp_q  <= ld_resp;
                            rlast_q  <= ld_last;
                            state    <= ld_state;
                            rvalid_q <= (ld_state == BEAT);
`ifdef YSYX_23060025_AXI_RD_RAND_DELAY_EN
                            gap_cnt  <= lfsr[1:0];
`endif
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (lat_cnt <= 4'd1) begin
                        rdata_q  <= ld_data;
                        rresp_q  <= ld_resp;
                        rlast_q  <= ld_last;
                        state    <= ld_state;
                        rvalid_q <= (ld_state == BEAT);
`ifdef YSYX_23060025_AXI_RD_RAND_DELAY_EN
                        gap_cnt  <= lfsr[1:0];
`endif
                    end
                end
                BEAT: begin
                    if (r_hs) begin
                        if (rlast_q) begin
                            state     <= IDLE;
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                        end else begin
                            addr     <= ld_addr;
                            beat_cnt <= ld_cnt;
                            rdata_q  <= ld_data;
                            rresp_q  <= ld_resp;
                            rlast_q  <= ld_last;
                            state    <= ld_state;
                            rvalid_q <= (ld_state == BEAT);
`ifdef YSYX_23060025_AXI_RD_RAND_DELAY_EN
                            gap_cnt  <= lfsr[1:0];
`endif
                        end
                    end
                end
`ifdef YSYX_23060025_AXI_RD_RAND_DELAY_EN
                // Reload at the end of the gap so writes landing meanwhile are seen.
                GAP: begin
                    gap_cnt <= gap_cnt - 2'd1;
                    if (gap_cnt == 2'd1) begin
                        rdata_q  <= ld_data;
                        rresp_q  <= ld_resp;
                        rlast_q  <= ld_last;
                        state    <= BEAT;
                        rvalid_q <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060025_axi_rd_slave.sv
// Randomized and directed bench for the AXI read responder against a behavioural burst model.
module tb_ysyx_23060025_axi_rd_slave;

    localparam int RL = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in_araddr;
    logic        in_arvalid;
    logic        in_arready;
    logic [7:0]  in_arlen;
    logic [2:0]  in_arsize;
    logic [1:0]  in_arburst;
    logic        in_rvalid;
    logic        in_rready;
    logic [31:0] in_rdata;
    logic [1:0]  in_rresp;
    logic        in_rlast;
    logic        mem_wen;
    logic [9:0]  mem_waddr;
    logic [31:0] mem_wdata;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model_mem [0:1023];

    always #5 clock = ~clock;

    ysyx_23060025_axi_rd_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH_W(10), .READ_LAT(RL)
    ) dut (
        .clock(clock), .reset(reset),
        .in_araddr(in_araddr), .in_arvalid(in_arvalid), .in_arready(in_arready),
        .in_arlen(in_arlen), .in_arsize(in_arsize), .in_arburst(in_arburst),
        .in_rvalid(in_rvalid), .in_rready(in_rready), .in_rdata(in_rdata),
        .in_rresp(in_rresp), .in_rlast(in_rlast),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bd_write(input int idx, input logic [31:0] d);
        @(negedge clock);
        mem_wen   = 1'b1;
        mem_waddr = idx[9:0];
        mem_wdata = d;
        model_mem[idx] = d;
        @(negedge clock);
        mem_wen   = 1'b0;
    endtask

    // mode: 0 rready held high, 1 pattern 1,0,0,1, 2 random.
    task automatic do_burst(input logic [31:0] a, input int len, input logic [2:0] sz,
                            input logic [1:0] bt, input int mode, input bit hold_ar,
                            input int wr_beat, input int wr_idx, input logic [31:0] wr_dat,
                            input int rst_beat);
        logic [31:0] exp_d[$];
        logic [1:0]  exp_r[$];
        logic [31:0] ca;
        bit          err;
        bit          done;
        int          k;
        int          t;
        int          p;
        err = (bt >= 2'd2) || (sz > 3'd2);
        ca  = a;
        for (int i = 0; i <= len; i++) begin
            exp_d.push_back(err ? 32'd0 : model_mem[(ca >> 2) % 1024]);
            exp_r.push_back(err ? 2'b10 : 2'b00);
            if (bt == 2'b01) ca = ca + (32'd1 << sz);
        end
        @(negedge clock);
        check("ar_idle", in_arready, 1);
        in_araddr  = a;
        in_arlen   = len[7:0];
        in_arsize  = sz;
        in_arburst = bt;
        in_arvalid = 1'b1;
        @(negedge clock);
        t = 1;
        if (hold_ar) in_araddr = ~a;
        else in_arvalid = 1'b0;
        check("wait_arready", in_arready, 0);
        check("wait_rvalid", in_rvalid, 0);
        k = 0;
        done = 0;
        while (!done && t < 2000) begin
            p = (t - RL) % 4;
            if (mode == 0) in_rready = 1'b1;
            else if (mode == 1) in_rready = (p == 0) || (p == 3);
            else in_rready = 1'($urandom_range(0, 1));
            if (t == RL) check("first_rvalid", in_rvalid, 1);
            if (in_rvalid) begin
                if (mode == 0) check("b2b_timing", t, RL + k);
                check("rdata", in_rdata, exp_d[k]);
                check("rresp", in_rresp, exp_r[k]);
                check("rlast", in_rlast, k == len);
                if (rst_beat == k) begin
                    reset      = 1'b1;
                    in_rready  = 1'b0;
                    in_arvalid = 1'b0;
                    @(negedge clock);
                    reset = 1'b0;
                    check("rst_rvalid", in_rvalid, 0);
                    check("rst_arready", in_arready, 1);
                    check("rst_rlast", in_rlast, 0);
                    return;
                end
                if (in_rready) begin
                    if (wr_beat == k + 1) begin
                        mem_wen   = 1'b1;
                        mem_waddr = wr_idx[9:0];
                        mem_wdata = wr_dat;
                    end
                    if (k == len) begin
                        done = 1;
                        in_arvalid = 1'b0;
                    end
                    k++;
                end
            end
            @(negedge clock);
            mem_wen = 1'b0;
            t++;
        end
        in_rready = 1'b0;
        if (wr_beat >= 0) model_mem[wr_idx] = wr_dat;
        if (!done) begin
            check("timeout", 0, 1);
        end else begin
            check("end_rvalid", in_rvalid, 0);
            check("end_arready", in_arready, 1);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [2:0]  rsz;
        logic [1:0]  rbt;
        reset      = 1'b1;
        in_araddr  = '0;
        in_arvalid = 1'b0;
        in_arlen   = '0;
        in_arsize  = '0;
        in_arburst = '0;
        in_rready  = 1'b0;
        mem_wen    = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        repeat (2) @(negedge clock);
        check("rst_arready", in_arready, 1);
        check("rst_rvalid", in_rvalid, 0);
        check("rst_rlast", in_rlast, 0);
        check("rst_rresp", in_rresp, 0);
        check("rst_rdata", in_rdata, 0);
        reset = 1'b0;

        for (int i = 0; i < 1024; i++) bd_write(i, $urandom);
        bd_write(0, 32'd11);
        bd_write(1, 32'd22);
        bd_write(2, 32'd33);
        bd_write(3, 32'd44);

        do_burst(32'h0, 3, 3'd2, 2'b01, 0, 0, -1, 0, 0, -1);
        do_burst(32'h0, 3, 3'd2, 2'b01, 1, 1, -1, 0, 0, -1);
        do_burst(32'h8, 0, 3'd2, 2'b01, 0, 0, -1, 0, 0, -1);
        do_burst(32'h4, 2, 3'd2, 2'b00, 0, 0, -1, 0, 0, -1);
        do_burst(32'hFFC, 1, 3'd2, 2'b01, 0, 0, -1, 0, 0, -1);
        do_burst(32'hFFFF_FFFC, 1, 3'd2, 2'b01, 1, 0, -1, 0, 0, -1);
        do_burst(32'h0, 1, 3'd2, 2'b10, 0, 0, -1, 0, 0, -1);
        do_burst(32'h0, 1, 3'd3, 2'b01, 0, 0, -1, 0, 0, -1);
        do_burst(32'h4, 2, 3'd2, 2'b11, 1, 0, -1, 0, 0, -1);
        do_burst(32'h0, 3, 3'd2, 2'b01, 0, 0, 1, 1, 32'h55, -1);
        do_burst(32'h0, 3, 3'd2, 2'b01, 0, 0, -1, 0, 0, -1);
        do_burst(32'h0, 3, 3'd2, 2'b01, 0, 0, -1, 0, 0, 1);
        do_burst(32'h0, 3, 3'd2, 2'b01, 0, 0, -1, 0, 0, -1);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) bd_write($urandom_range(0, 1023), $urandom);
            ra  = $urandom;
            rsz = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            rbt = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            do_burst(ra, $urandom_range(0, 7), rsz, rbt, (n % 3 == 0) ? 0 : 2,
                     1'($urandom_range(0, 1)), -1, 0, 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060025_axi_rd_slave.md
Name: ysyx_23060025_axi_rd_slave

Overview:
- AXI4 read-channel responder (AR/R only) backed by an internal word-addressed memory.
- It is the far end of the burst-read master used by the instruction cache and the LSU.
- It serves FIXED and INCR bursts with a configurable first-beat latency and returns SLVERR for unsupported requests.
- A backdoor write port preloads and patches memory for simulation and boot images.

Parameters:
- ADDR_WIDTH, 32, AR address width.
- DATA_WIDTH, 32, R data width; fixed 4-byte beats.
- MEM_DEPTH_W, 10, log2 of memory depth in 32-bit words.
- READ_LAT, 2, cycles from AR handshake to first rvalid; legal values are 1..15.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_araddr  in  ADDR_WIDTH  burst start address.
- in_arvalid  in  1  address valid.
- in_arready  out  1  address accepted.
- in_arlen  in  8  beats minus 1.
- in_arsize  in  3  bytes per beat, log2.
- in_arburst  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- in_rvalid  out  1  read data valid.
- in_rready  in  1  master accepts a beat.
- in_rdata  out  DATA_WIDTH  beat data.
- in_rresp  out  2  00 OKAY, 10 SLVERR.
- in_rlast  out  1  final beat of the burst.
- mem_wen  in  1  backdoor write enable.
- mem_waddr  in  MEM_DEPTH_W  backdoor word index.
- mem_wdata  in  DATA_WIDTH  backdoor write data.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high and is sampled only at the clock edge.
- Reset values:
  - State is IDLE, so in_arready=1.
  - in_rvalid=0, in_rlast=0, in_rresp=00, in_rdata=0.
  - Beat counter and latency counter are 0.
  - Memory contents are NOT reset.
- States:
  - IDLE: in_arready=1. On arvalid&arready, latch addr, len, size and burst, set the latency counter to READ_LAT-1, go to WAIT.
  - WAIT: in_arready=0 and in_rvalid=0. Decrement the counter. When it is 0, load beat 0 into the registered rdata/rresp/rlast and go to BEAT.
  - BEAT: in_rvalid=1.
    - Beat not accepted: hold rdata, rresp and rlast stable until rready.
    - rvalid&rready on a non-last beat: advance the address, load the next beat at the same edge, and stay in BEAT. Beats run back-to-back with no bubble.
    - rvalid&rready on the last beat (in_rlast=1): go to IDLE; in_rvalid=0 and in_arready=1 in the next cycle.
- Latency:
  - With AR handshake in cycle N, the first rvalid appears in cycle N+READ_LAT.
  - A burst of L+1 beats with rready held high completes in cycle N+READ_LAT+L.
- Address arithmetic:
  - Word index = addr[MEM_DEPTH_W+1:2].
  - Upper bits are ignored, so addresses alias modulo the memory size.
  - Low two bits are ignored; the full aligned word is always returned.
- Address update per beat:
  - INCR: addr += (1<<arsize), wrapping modulo 2^ADDR_WIDTH.
  - FIXED: addr is unchanged.
- Error handling:
  - Triggered by arburst=WRAP or 11, or arsize>2.
  - The full arlen+1 beats are still returned, each with rdata=0 and rresp=10; rlast is asserted on the final beat.
  - A normal request returns rresp=00 on every beat.
- rlast is 1 exactly when the beat counter equals the latched arlen. arlen=0 gives one beat with rlast=1.
- Only one outstanding burst is allowed; arvalid asserted outside IDLE is ignored (arready=0).
- Backdoor write vs. read:
  - A write lands at the clock edge.
  - A beat loaded at the same edge reads the old word (read-before-write).
  - A beat loaded later sees the new word.
  - Writes are accepted in every state, including WAIT and BEAT.
- Reset mid-burst: state returns to IDLE and rvalid drops at that edge. The remaining beats are discarded and no rlast is sent.

Optional Feature:
- Macro: YSYX_23060025_AXI_RD_RAND_DELAY_EN.
- Defined:
  - An 8-bit LFSR (seed 8'hA5 at reset, polynomial x^8+x^6+x^5+x^4+1) steps every cycle.
  - Before each beat, including beat 0 after READ_LAT, the block inserts lfsr[1:0] extra cycles with rvalid=0, in a GAP state.
  - Data and order are unchanged.
- Undefined: no GAP state; timing is exactly as described in Behaviour.

Test Plan:
- Preload words 0..3 with 11,22,33,44. INCR, araddr=0x0, arlen=3, arsize=2, rready=1, READ_LAT=2 -> rdata 11,22,33,44 in cycles N+2..N+5, rlast only at N+5, rresp=00, arready=1 at N+6.
- Same burst with rready toggled 1,0,0,1,... -> each beat is held stable while rready=0, with no loss or duplication. arlen=0 at 0x8 -> a single beat of 33 with rlast=1.
- FIXED, araddr=0x4, arlen=2 -> rdata 22,22,22. INCR at the top word (word 1023), arlen=1 -> word 1023 then word 0 (alias wrap).
- arburst=10, arlen=1 -> 2 beats, rdata=0, rresp=10, rlast on beat 2. arsize=3 gives the same result.
- mem_wen to word 1 (wdata=0x55) in the edge that loads beat 1 -> 22 is returned. Repeat the burst -> 0x55 is returned.
- Assert reset during BEAT after beat 1 -> rvalid=0 next cycle, arready=1. A new burst then returns correct data from beat 0.
